pdm_capture_writer: RTL and testbench
=====================================

// Module: pdm_capture_writer
// PURPOSE
// - Parametrised successor to the AudioInput capture path: converts 1-bit PDM mic data into
//   signed PCM samples by boxcar decimation and streams them into a circular delay buffer.
// - Sits between the mic synchroniser and the BRAM write port (wea/addra/dina).
// - Adds a clock-enable, run control, programmable wrap length and saturating scaling.
// PARAMETERS
// - ADDR_W  16  buffer address width
// - DATA_W  16  PCM sample width (signed two's complement)
// - DECIM   64  PDM bits per sample; power of two, >=4, log2(DECIM) <= DATA_W-2
// PORTS
// - clk            in   1       capture clock
// - sysreset_n     in   1       asynchronous active-low reset
// - run            in   1       capture enable (level)
// - pdm_ce         in   1       qualifies pdm_in; one PDM bit per cycle with pdm_ce=1
// - pdm_in         in   1       synchronised PDM bit
// - wrap_limit     in   ADDR_W  last valid address of circular buffer
// - write_enable   out  1       one-cycle BRAM write strobe
// - write_address  out  ADDR_W  BRAM write address
// - write_data     out  DATA_W  PCM sample
// - wrap_pulse     out  1       high with the write_enable that writes address wrap_limit
// BEHAVIOUR
// - Reset (async assert, sync release): all outputs 0, bit counter 0, ones counter 0, state IDLE.
// - FSM: IDLE -> ACQ when run=1; ACQ -> WRITE when the DECIM-th bit of a window is taken;
//   WRITE -> ACQ (run=1) or IDLE (run=0) after one cycle; ACQ -> IDLE when run=0.
// - IDLE: ones/bit counters held at 0; write_address reset to 0 (each rising run restarts at 0).
// - ACQ: on pdm_ce=1, bit_cnt++ and ones += pdm_in; pdm_in ignored when pdm_ce=0.
// - Window close: on the ce-cycle taking bit DECIM-1, the sample is registered; write_enable=1 in
//   the next cycle (latency 1 clk from last bit). write_address/write_data valid while
//   write_enable=1 and held afterwards. Counters restart for next window in the same close cycle,
//   so no PDM bit is lost if pdm_ce=1 during WRITE.
// - Scaling: S = log2(DECIM); raw = 2*ones - DECIM (range -DECIM..+DECIM);
//   write_data = raw << (DATA_W-S-1), saturated to 2^(DATA_W-1)-1 (only raw=+DECIM saturates).
// - Address: write_address used for the write, then next = (addr >= wrap_limit) ? 0 : addr+1.
//   wrap_limit=0 -> every write to address 0, wrap_pulse on every write.
//   wrap_limit lowered below current addr -> next write goes to 0 (no out-of-range write).
// - run falls mid-window: partial window discarded, no write; run falls in WRITE: write completes.
// - Reset mid-window: partial window discarded; first post-reset window is a full DECIM bits.
// CONFIGURATION
// - PDM_CAPTURE_DC_BLOCK_EN defined: first-order DC-removal on scaled samples,
//   y[n] = x[n] - x[n-1] + y[n-1] - (y[n-1] >>> 8), DATA_W+2 bit internal, saturated to DATA_W;
//   adds one FILTER state between ACQ and WRITE (write latency 2 clk from last bit);
//   x/y history cleared by reset and on entry to IDLE.
// - Not defined: no filter, no FILTER state, write_data = scaled sample, latency 1 clk.
// TESTING (defaults, pdm_ce=1 every cycle, filter macro off unless noted)
// - pdm_in=1 constant, wrap_limit=0xFFFF -> write every 64 clk, data 0x7FFF, addr 0,1,2,...
// - pdm_in alternating 1/0 -> data 0x0000 each window; pdm_in=0 constant -> data 0x8000.
// - 48 ones then 16 zeros per window -> raw=32, data 0x4000; pdm_ce=1 every 4th clk ->
//   writes spaced 256 clk, same data.
// - wrap_limit=3 -> addresses 0,1,2,3,0,1; wrap_pulse=1 only on writes to addr 3.
// - run dropped after 30 bits, raised 10 clk later -> no write in between; next write at addr 0
//   after full 64 bits; sysreset_n pulsed mid-window -> outputs 0, next window full 64 bits.
// - PDM_CAPTURE_DC_BLOCK_EN, pdm_in=1 constant -> first data 0x7FFF, then decays toward 0;
//   write_enable 2 clk after last bit.

Source files
------------

// File: rtl/pdm_capture_writer_if.sv
// BRAM write-port bundle for the PDM capture writer.
// Master drives the strobe, address, sample and wrap marker.
interface pdm_capture_writer_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    logic              write_enable;
    logic [ADDR_W-1:0] write_address;
    logic [DATA_W-1:0] write_data;
    logic              wrap_pulse;

    modport master (
        output write_enable,
        output write_address,
        output write_data,
        output wrap_pulse
    );

    modport slave (
        input write_enable,
        input write_address,
        input write_data,
        input wrap_pulse
    );
endinterface

// File: rtl/pdm_capture_writer.sv
// PDM to PCM boxcar decimator streaming into a circular BRAM buffer.
// Optional DC-removal filter: define PDM_CAPTURE_DC_BLOCK_EN.
module pdm_capture_writer #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16,
    parameter int DECIM  = 64
) (
    input  logic              clk,
    input  logic              sysreset_n,
    input  logic              run,
    input  logic              pdm_ce,
    input  logic              pdm_in,
    input  logic [ADDR_W-1:0] wrap_limit,
    pdm_capture_writer_if.master wr
);
    localparam int S  = $clog2(DECIM);
    localparam int SH = DATA_W - S - 1;
    localparam logic [DATA_W-1:0] MAX_V = {1'b0, {(DATA_W-1){1'b1}}};

`ifdef PDM_CAPTURE_DC_BLOCK_EN
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACQ    = 2'd1,
        WRITE  = 2'd2,
        FILTER = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACQ    = 2'd1,
        WRITE  = 2'd2
    } state_t;
`endif

    state_t            state;
    state_t            state_nx;
    logic [S-1:0]      bit_cnt;
    logic [S:0]        ones;
    logic [S:0]        ones_sum;
    logic              take;
    logic              close;
    logic [DATA_W-1:0] raw;
    logic [DATA_W-1:0] shifted;
    logic [DATA_W-1:0] scaled;
    logic [ADDR_W-1:0] next_addr;
    logic [ADDR_W-1:0] use_addr;
    logic              commit;
    logic [DATA_W-1:0] commit_data;

    // Bits are only taken while capturing; the window closes on bit DECIM-1.
    assign take     = run && pdm_ce && (state != IDLE);
    assign close    = take && (state == ACQ) && (bit_cnt == '1);
    assign ones_sum = ones + {{S{1'b0}}, pdm_in};

    // 2*ones - DECIM fits DATA_W bits; only the all-ones window overflows.
    assign raw     = DATA_W'({ones_sum, 1'b0}) - DATA_W'(DECIM);
    assign shifted = raw << SH;

    // Saturate the single positive full-scale case.
    always_comb begin
        scaled = shifted;
        if (ones_sum[S]) begin
            scaled = MAX_V;
        end
    end

    // A write lowered below the pending address falls back to 0.
    assign use_addr = (next_addr > wrap_limit) ? '0 : next_addr;

`ifdef PDM_CAPTURE_DC_BLOCK_EN
    localparam logic signed [DATA_W+1:0] Y_MAX = (DATA_W+2)'(2 ** (DATA_W - 1) - 1);
    localparam logic signed [DATA_W+1:0] Y_MIN = -(DATA_W+2)'(2 ** (DATA_W - 1));

    logic signed [DATA_W-1:0] x_q;
    logic signed [DATA_W-1:0] x_prev;
    logic signed [DATA_W-1:0] y_prev;
    logic signed [DATA_W-1:0] y_dec;
    logic signed [DATA_W+1:0] y_full;
    logic        [DATA_W-1:0] y_sat;

    assign y_dec  = y_prev >>> 8;
    assign y_full = {{2{x_q[DATA_W-1]}}, x_q}
                  - {{2{x_prev[DATA_W-1]}}, x_prev}
                  + {{2{y_prev[DATA_W-1]}}, y_prev}
                  - {{2{y_dec[DATA_W-1]}}, y_dec};

    // Clamp the wide filter result back into the sample range.
    always_comb begin
        y_sat = y_full[DATA_W-1:0];
        if (y_full > Y_MAX) begin
            y_sat = Y_MAX[DATA_W-1:0];
        end else if (y_full < Y_MIN) begin
            y_sat = Y_MIN[DATA_W-1:0];
        end
    end

    assign commit      = (state == FILTER);
    assign commit_data = y_sat;

    // Filter history: capture sample at close, advance in FILTER, clear when idle.
    always_ff @(posedge clk or negedge sysreset_n) begin
        if (!sysreset_n) begin
            x_q    <= '0;
            x_prev <= '0;
            y_prev <= '0;
        end else if (state == IDLE) begin
            x_q    <= '0;
            x_prev <= '0;
            y_prev <= '0;
        end else begin
            if (close) begin
                x_q <= $signed(scaled);
            end
            if (state == FILTER) begin
                x_prev <= x_q;
                y_prev <= $signed(y_sat);
            end
        end
    end
`else
    assign commit      = close;
    assign commit_data = scaled;
`endif

    // State register.
    always_ff @(posedge clk or negedge sysreset_n) begin
        if (!sysreset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic; a closed window always reaches WRITE.
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (run) begin
                    state_nx = ACQ;
                end
            end
            ACQ: begin
                if (!run) begin
                    state_nx = IDLE;
                end else if (close) begin
`ifdef PDM_CAPTURE_DC_BLOCK_EN
                    state_nx = FILTER;
`else
                    state_nx = WRITE;
`endif
                end
            end
`ifdef PDM_CAPTURE_DC_BLOCK_EN
            FILTER: begin
                state_nx = WRITE;
            end
`endif
            WRITE: begin
                state_nx = run ? ACQ : IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // Window counters restart in the close cycle so no bit is lost.
    always_ff @(posedge clk or negedge sysreset_n) begin
        if (!sysreset_n) begin
            bit_cnt <= '0;
            ones    <= '0;
        end else if (state == IDLE) begin
            bit_cnt <= '0;
            ones    <= '0;
        end else if (take) begin
            bit_cnt <= bit_cnt + 1'b1;
            ones    <= close ? '0 : ones_sum;
        end
    end

    // Write port: one-cycle strobe, address/data held between writes.
    always_ff @(posedge clk or negedge sysreset_n) begin
        if (!sysreset_n) begin
            wr.write_enable  <= 1'b0;
            wr.write_address <= '0;
            wr.write_data    <= '0;
            wr.wrap_pulse    <= 1'b0;
            next_addr        <= '0;
        end else if (state == IDLE) begin
            wr.write_enable  <= 1'b0;
            wr.write_address <= '0;
            wr.wrap_pulse    <= 1'b0;
            next_addr        <= '0;
        end else if (commit) begin
            wr.write_enable  <= 1'b1;
            wr.write_address <= use_addr;
            wr.write_data    <= commit_data;
            wr.wrap_pulse    <= (use_addr == wrap_limit);
            next_addr        <= (use_addr >= wrap_limit) ? '0 : use_addr + 1'b1;
        end else begin
            wr.write_enable  <= 1'b0;
            wr.wrap_pulse    <= 1'b0;
        end
    end
endmodule

// File: tb/tb_pdm_capture_writer.sv
// Scoreboard bench for pdm_capture_writer: window-level reference model
// pushes expected writes, a negedge monitor pops and compares them.
module tb_pdm_capture_writer;
    localparam int AW    = 16;
    localparam int DW    = 16;
    localparam int DECIM = 64;
    localparam int S     = 6;
`ifdef PDM_CAPTURE_DC_BLOCK_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic          clk = 1'b0;
    logic          sysreset_n = 1'b0;
    logic          run = 1'b0;
    logic          pdm_ce = 1'b0;
    logic          pdm_in = 1'b0;
    logic [AW-1:0] wrap_limit = '1;

    pdm_capture_writer_if #(.ADDR_W(AW), .DATA_W(DW)) wr();

    pdm_capture_writer #(.ADDR_W(AW), .DATA_W(DW), .DECIM(DECIM)) dut (
        .clk        (clk),
        .sysreset_n (sysreset_n),
        .run        (run),
        .pdm_ce     (pdm_ce),
        .pdm_in     (pdm_in),
        .wrap_limit (wrap_limit),
        .wr         (wr)
    );

    always #5 clk = ~clk;

    typedef struct {
        int            due;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic          pulse;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int total = 0;
    int bad = 0;
    int edge_n = 0;
    bit armed = 0;
    int nbits = 0;
    int ones = 0;
    int na = 0;
    int xp = 0;
    int yp = 0;
    int pat = 0;
    int ce_mode = 0;
    int cyc_i = 0;
    logic [DW-1:0] last_data = '0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at edge %0d", nm, act, req, edge_n);
        end
    endtask

    // Reference: a finished window of DECIM bits becomes one write.
    task automatic close_window();
        int v;
        int use_a;
        exp_t e;
        v = (2 * ones - DECIM) * (1 << (DW - S - 1));
        if (v > 32767) v = 32767;
`ifdef PDM_CAPTURE_DC_BLOCK_EN
        begin
            int y;
            y = v - xp + yp - (yp >>> 8);
            if (y > 32767) y = 32767;
            if (y < -32768) y = -32768;
            xp = v;
            yp = y;
            v = y;
        end
`endif
        use_a = (na > int'(wrap_limit)) ? 0 : na;
        e.due   = edge_n + LAT - 1;
        e.addr  = AW'(use_a);
        e.data  = DW'(v);
        e.pulse = (use_a == int'(wrap_limit));
        na = (use_a >= int'(wrap_limit)) ? 0 : use_a + 1;
        q.push_back(e);
    endtask

    // Model: capture is armed one edge after run is seen; run low discards all.
    always @(posedge clk or negedge sysreset_n) begin
        if (!sysreset_n) begin
            armed = 0;
            nbits = 0;
            ones  = 0;
            na    = 0;
            xp    = 0;
            yp    = 0;
            q.delete();
        end else begin
            edge_n++;
            if (!armed) begin
                na = 0;
                xp = 0;
                yp = 0;
                if (run) armed = 1;
            end else if (!run) begin
                armed = 0;
                nbits = 0;
                ones  = 0;
                na    = 0;
                xp    = 0;
                yp    = 0;
            end else if (pdm_ce) begin
                nbits++;
                ones += int'(pdm_in);
                if (nbits == DECIM) begin
                    close_window();
                    nbits = 0;
                    ones  = 0;
                end
            end
        end
    end

    // Monitor: every strobe must match the oldest expected write.
    always @(negedge clk) begin
        if (sysreset_n) begin
            if (wr.write_enable) begin
                if (q.size() == 0) begin
                    check("unexpected_write", 32'(wr.write_enable), 32'd0);
                end else begin
                    mon_e = q.pop_front();
                    check("write_edge", 32'(edge_n), 32'(mon_e.due));
                    check("write_address", 32'(wr.write_address), 32'(mon_e.addr));
                    check("write_data", 32'(wr.write_data), 32'(mon_e.data));
                    check("wrap_pulse", 32'(wr.wrap_pulse), 32'(mon_e.pulse));
                    last_data = wr.write_data;
                end
            end else if (q.size() > 0 && q[0].due <= edge_n) begin
                check("write_seen", 32'(wr.write_enable), 32'd1);
                void'(q.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        cyc_i++;
        case (ce_mode)
            0: pdm_ce = 1'b1;
            1: pdm_ce = (cyc_i % 4 == 0);
            default: pdm_ce = ($urandom_range(0, 2) != 0);
        endcase
        case (pat)
            0: pdm_in = 1'b1;
            1: pdm_in = 1'b0;
            2: pdm_in = (nbits % 2 == 0);
            3: pdm_in = (nbits < 48);
            default: pdm_in = 1'($urandom);
        endcase
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    task automatic wait_bits(input int target);
        for (int i = 0; i < 400 && nbits != target; i++) tick();
        if (nbits != target) check("reach_window_bit", 32'(nbits), 32'(target));
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_we"}, 32'(wr.write_enable), 32'd0);
        check({tag, "_addr"}, 32'(wr.write_address), 32'd0);
        check({tag, "_data"}, 32'(wr.write_data), 32'd0);
        check({tag, "_pulse"}, 32'(wr.wrap_pulse), 32'd0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check_outputs_zero("reset");
        sysreset_n = 1'b1;

        pat = 0; ce_mode = 0; run = 1'b1;
        ticks(64 * 3 + 10);
`ifndef PDM_CAPTURE_DC_BLOCK_EN
        check("data_all_ones", 32'(last_data), 32'h7fff);
`endif
        pat = 2;
        ticks(64 * 2 + 4);
`ifndef PDM_CAPTURE_DC_BLOCK_EN
        check("data_alternating", 32'(last_data), 32'h0000);
`endif
        pat = 1;
        ticks(64 * 2 + 4);
`ifndef PDM_CAPTURE_DC_BLOCK_EN
        check("data_all_zeros", 32'(last_data), 32'h8000);
`endif
        pat = 3;
        ticks(64 * 2 + 4);
`ifndef PDM_CAPTURE_DC_BLOCK_EN
        check("data_48_16", 32'(last_data), 32'h4000);
`endif
        ce_mode = 1;
        ticks(256 * 2 + 8);
`ifndef PDM_CAPTURE_DC_BLOCK_EN
        check("data_ce_div4", 32'(last_data), 32'h4000);
`endif

        ce_mode = 0; pat = 4; run = 1'b0;
        ticks(3);
        wrap_limit = 16'd3; run = 1'b1;
        ticks(64 * 7);

        run = 1'b0;
        ticks(3);
        wrap_limit = 16'd0; run = 1'b1;
        ticks(64 * 3);

        run = 1'b0;
        ticks(3);
        wrap_limit = '1; run = 1'b1;
        ticks(64 * 2);
        wait_bits(30);
        run = 1'b0;
        ticks(10);
        run = 1'b1;
        ticks(64 * 5);
        wait_bits(20);
        wrap_limit = 16'd1;
        ticks(64 * 3);

        wait_bits(25);
        sysreset_n = 1'b0;
        #2;
        check_outputs_zero("midreset");
        @(posedge clk);
        #1;
        sysreset_n = 1'b1;
        ticks(64 * 3);

        ce_mode = 2; pat = 4;
        for (int i = 0; i < 4000; i++) begin
            tick();
            if ($urandom_range(0, 299) == 0) begin
                run = 1'b0;
                ticks($urandom_range(3, 8));
                run = 1'b1;
            end
            if (nbits >= 8 && nbits <= 50 && $urandom_range(0, 199) == 0) begin
                wrap_limit = AW'($urandom_range(0, 7));
            end
        end

        run = 1'b0;
        ticks(6);
        check("queue_drained", 32'(q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
